// File: rtl/sequencer_job_scheduler.sv
// Job scheduler between the host CSR block and the acquisition sequencer: queues host jobs in a small
// FIFO and launches them one at a time, holding each job's settings for the whole run.
package sequencer_job_scheduler_pkg;
  typedef struct packed {
    logic        with_galvo;
    logic [6:0]  num_slm_images;
    logic [15:0] cycles;
    logic [31:0] num_galvo;
    logic [7:0]  cam_ms;
    logic [7:0]  galvo_ms;
  } job_t;
endpackage

module sequencer_job_scheduler
  import sequencer_job_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 2,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iJOB_VALID,
  output logic                  oJOB_READY,
  input  logic                  iJOB_WITH_GALVO,
  input  logic [6:0]            iJOB_NUM_SLM_IMAGES,
  input  logic [15:0]           iJOB_CYCLES,
  input  logic [31:0]           iJOB_NUM_GALVO,
  input  logic [7:0]            iJOB_CAM_MS,
  input  logic [7:0]            iJOB_GALVO_MS,
  input  logic                  iABORT,
  output logic [6:0]            oSEQ_NUM_SLM_IMAGES,
  output logic [15:0]           oSEQ_CYCLES,
  output logic [31:0]           oSEQ_NUM_GALVO,
  output logic [7:0]            oSEQ_CAM_MS,
  output logic [7:0]            oSEQ_GALVO_MS,
  output logic                  oSEQ_TRIG_WITH_GALVO,
  output logic                  oSEQ_TRIG_WITHOUT_GALVO,
  input  logic                  iSEQ_BUSY,
  output logic                  oACTIVE,
  output logic [DEPTH_LOG2:0]   oQUEUE_COUNT,
  output logic [15:0]           oJOBS_DONE,
  output logic                  oERR_BAD_JOB,
  output logic                  oERR_TIMEOUT
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_TRIG      = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  job_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TMR_W-1:0] r_timer;
  job_t             r_job;
  logic             r_trig_g;
  logic             r_trig_ng;
  logic             r_active;
  logic [15:0]      r_jobs_done;
  logic             r_err_bad;
  logic             r_err_to;

  logic             w_full;
  logic             w_bad;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_timeout;
  logic             w_done_inc;
  job_t             w_job_in;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign oJOB_READY = !w_full && !iABORT;
  assign w_bad      = (iJOB_NUM_SLM_IMAGES == 7'd0) || (iJOB_CYCLES == 16'd0) ||
                      (iJOB_WITH_GALVO && (iJOB_NUM_GALVO == 32'd0));
  assign w_accept   = iJOB_VALID && oJOB_READY;
  assign w_push     = w_accept && !w_bad;

  assign w_job_in = '{with_galvo:     iJOB_WITH_GALVO,
                      num_slm_images: iJOB_NUM_SLM_IMAGES,
                      cycles:         iJOB_CYCLES,
                      num_galvo:      iJOB_NUM_GALVO,
                      cam_ms:         iJOB_CAM_MS,
                      galvo_ms:       iJOB_GALVO_MS};

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes; LOAD re-checks count in case an abort emptied the FIFO
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_timeout   = 1'b0;
    w_done_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !iSEQ_BUSY) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_TRIG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TRIG: begin
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (iSEQ_BUSY) begin
          w_state_nxt = S_RUN;
        end else if (r_timer == TMR_W'(START_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!iSEQ_BUSY) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_inc  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO storage has no reset; only entries below the count are ever read
  always_ff @(posedge iCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_job_in;
  end

  // FIFO pointers, launch settings, trigger pulses, counters and sticky errors
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_job       <= '0;
      r_trig_g    <= 1'b0;
      r_trig_ng   <= 1'b0;
      r_active    <= 1'b0;
      r_jobs_done <= '0;
      r_err_bad   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      if (iABORT) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end

      if (w_pop) r_job <= r_mem[r_rd_ptr];

      if (r_state == S_TRIG)           r_timer <= '0;
      else if (r_state == S_WAIT_BUSY) r_timer <= r_timer + TMR_W'(1);

      r_trig_g  <= (r_state == S_TRIG) && r_job.with_galvo;
      r_trig_ng <= (r_state == S_TRIG) && !r_job.with_galvo;
      r_active  <= (w_state_nxt != S_IDLE);

      if (w_done_inc)         r_jobs_done <= r_jobs_done + 16'd1;
      if (w_accept && w_bad)  r_err_bad   <= 1'b1;
      if (w_timeout)          r_err_to    <= 1'b1;
    end
  end

  assign oSEQ_NUM_SLM_IMAGES     = r_job.num_slm_images;
  assign oSEQ_CYCLES             = r_job.cycles;
  assign oSEQ_NUM_GALVO          = r_job.num_galvo;
  assign oSEQ_CAM_MS             = r_job.cam_ms;
  assign oSEQ_GALVO_MS           = r_job.galvo_ms;
  assign oSEQ_TRIG_WITH_GALVO    = r_trig_g;
  assign oSEQ_TRIG_WITHOUT_GALVO = r_trig_ng;
  assign oACTIVE                 = r_active;
  assign oQUEUE_COUNT            = r_count;
  assign oJOBS_DONE              = r_jobs_done;
  assign oERR_BAD_JOB            = r_err_bad;
  assign oERR_TIMEOUT            = r_err_to;

endmodule

// File: tb/tb_sequencer_job_scheduler.sv
// Self-checking bench for sequencer_job_scheduler: directed scenarios plus randomized episodes checked
// against a queue-based model of the job stream and a bench-side sequencer responder.
module tb_sequencer_job_scheduler;

  localparam int unsigned DEPTH_LOG2    = 2;
  localparam int unsigned DEPTH         = 4;
  localparam int unsigned START_TIMEOUT = 64;

  typedef struct packed {
    logic        with_galvo;
    logic [6:0]  images;
    logic [15:0] cycles;
    logic [31:0] num_galvo;
    logic [7:0]  cam_ms;
    logic [7:0]  galvo_ms;
  } job_t;

  logic              iCLK;
  logic              iRST;
  logic              iJOB_VALID;
  logic              oJOB_READY;
  logic              iJOB_WITH_GALVO;
  logic [6:0]        iJOB_NUM_SLM_IMAGES;
  logic [15:0]       iJOB_CYCLES;
  logic [31:0]       iJOB_NUM_GALVO;
  logic [7:0]        iJOB_CAM_MS;
  logic [7:0]        iJOB_GALVO_MS;
  logic              iABORT;
  logic [6:0]        oSEQ_NUM_SLM_IMAGES;
  logic [15:0]       oSEQ_CYCLES;
  logic [31:0]       oSEQ_NUM_GALVO;
  logic [7:0]        oSEQ_CAM_MS;
  logic [7:0]        oSEQ_GALVO_MS;
  logic              oSEQ_TRIG_WITH_GALVO;
  logic              oSEQ_TRIG_WITHOUT_GALVO;
  logic              iSEQ_BUSY;
  logic              oACTIVE;
  logic [DEPTH_LOG2:0] oQUEUE_COUNT;
  logic [15:0]       oJOBS_DONE;
  logic              oERR_BAD_JOB;
  logic              oERR_TIMEOUT;

  sequencer_job_scheduler #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .iCLK                    (iCLK),
    .iRST                    (iRST),
    .iJOB_VALID              (iJOB_VALID),
    .oJOB_READY              (oJOB_READY),
    .iJOB_WITH_GALVO         (iJOB_WITH_GALVO),
    .iJOB_NUM_SLM_IMAGES     (iJOB_NUM_SLM_IMAGES),
    .iJOB_CYCLES             (iJOB_CYCLES),
    .iJOB_NUM_GALVO          (iJOB_NUM_GALVO),
    .iJOB_CAM_MS             (iJOB_CAM_MS),
    .iJOB_GALVO_MS           (iJOB_GALVO_MS),
    .iABORT                  (iABORT),
    .oSEQ_NUM_SLM_IMAGES     (oSEQ_NUM_SLM_IMAGES),
    .oSEQ_CYCLES             (oSEQ_CYCLES),
    .oSEQ_NUM_GALVO          (oSEQ_NUM_GALVO),
    .oSEQ_CAM_MS             (oSEQ_CAM_MS),
    .oSEQ_GALVO_MS           (oSEQ_GALVO_MS),
    .oSEQ_TRIG_WITH_GALVO    (oSEQ_TRIG_WITH_GALVO),
    .oSEQ_TRIG_WITHOUT_GALVO (oSEQ_TRIG_WITHOUT_GALVO),
    .iSEQ_BUSY               (iSEQ_BUSY),
    .oACTIVE                 (oACTIVE),
    .oQUEUE_COUNT            (oQUEUE_COUNT),
    .oJOBS_DONE              (oJOBS_DONE),
    .oERR_BAD_JOB            (oERR_BAD_JOB),
    .oERR_TIMEOUT            (oERR_TIMEOUT)
  );

  initial iCLK = 1'b0;
  always #10 iCLK = ~iCLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: queued jobs, completed count, sticky errors, job currently on the sequencer
  job_t        mq[$];
  logic [15:0] m_done = 16'd0;
  logic        m_bad  = 1'b0;
  logic        m_to   = 1'b0;
  job_t        cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input job_t j);
    return (j.images == 7'd0) || (j.cycles == 16'd0) || (j.with_galvo && (j.num_galvo == 32'd0));
  endfunction

  function automatic job_t mk_job(input logic g, input int unsigned img, input int unsigned cyc,
                                  input int unsigned ng, input int unsigned cam, input int unsigned gms);
    job_t j;
    j.with_galvo = g;
    j.images     = 7'(img);
    j.cycles     = 16'(cyc);
    j.num_galvo  = ng;
    j.cam_ms     = 8'(cam);
    j.galvo_ms   = 8'(gms);
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j = mk_job(1'($urandom_range(0, 1)), $urandom_range(1, 127), $urandom_range(1, 65535),
               $urandom_range(1, 100000), $urandom_range(0, 255), $urandom_range(0, 255));
    case ($urandom_range(0, 7))
      0: j.images = 7'd0;
      1: j.cycles = 16'd0;
      2: begin j.with_galvo = 1'b1; j.num_galvo = 32'd0; end
      3: begin j.with_galvo = 1'b0; j.num_galvo = 32'd0; end
      default: ;
    endcase
    return j;
  endfunction

  task automatic check_settings(input job_t j);
    check("seq_images",   64'(oSEQ_NUM_SLM_IMAGES), 64'(j.images));
    check("seq_cycles",   64'(oSEQ_CYCLES),         64'(j.cycles));
    check("seq_galvo",    64'(oSEQ_NUM_GALVO),      64'(j.num_galvo));
    check("seq_cam_ms",   64'(oSEQ_CAM_MS),         64'(j.cam_ms));
    check("seq_galvo_ms", 64'(oSEQ_GALVO_MS),       64'(j.galvo_ms));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_settings"}, {oSEQ_NUM_SLM_IMAGES, oSEQ_CYCLES, oSEQ_NUM_GALVO[7:0], oSEQ_CAM_MS,
                              oSEQ_GALVO_MS}, 64'd0);
    check({tag, "_galvo_hi"}, 64'(oSEQ_NUM_GALVO), 64'd0);
    check({tag, "_trig"},     64'({oSEQ_TRIG_WITH_GALVO, oSEQ_TRIG_WITHOUT_GALVO}), 64'd0);
    check({tag, "_active"},   64'(oACTIVE), 64'd0);
    check({tag, "_qcount"},   64'(oQUEUE_COUNT), 64'd0);
    check({tag, "_done"},     64'(oJOBS_DONE), 64'd0);
    check({tag, "_errs"},     64'({oERR_BAD_JOB, oERR_TIMEOUT}), 64'd0);
  endtask

  // One clock: move to the next falling edge and check the always-valid outputs
  task automatic cyc(input bit trig_here = 1'b0);
    @(negedge iCLK);
    check("jobs_done",   64'(oJOBS_DONE),   64'(m_done));
    check("err_bad",     64'(oERR_BAD_JOB), 64'(m_bad));
    check("err_timeout", 64'(oERR_TIMEOUT), 64'(m_to));
    if (!trig_here)
      check("no_trig", 64'({oSEQ_TRIG_WITH_GALVO, oSEQ_TRIG_WITHOUT_GALVO}), 64'd0);
  endtask

  // Host offers (or not) a job for one cycle, optionally with abort
  task automatic push_cycle(input bit valid, input job_t j, input bit abort);
    bit exp_ready;
    iJOB_VALID          = valid;
    iJOB_WITH_GALVO     = j.with_galvo;
    iJOB_NUM_SLM_IMAGES = j.images;
    iJOB_CYCLES         = j.cycles;
    iJOB_NUM_GALVO      = j.num_galvo;
    iJOB_CAM_MS         = j.cam_ms;
    iJOB_GALVO_MS       = j.galvo_ms;
    iABORT              = abort;
    #1;
    exp_ready = (mq.size() < DEPTH) && !abort;
    check("job_ready", 64'(oJOB_READY), 64'(exp_ready));
    if (abort) mq.delete();
    else if (valid && exp_ready) begin
      if (is_bad(j)) m_bad = 1'b1;
      else           mq.push_back(j);
    end
    cyc();
    iJOB_VALID = 1'b0;
    iABORT     = 1'b0;
    check("qcount", 64'(oQUEUE_COUNT), 64'(mq.size()));
  endtask

  // The head job must launch exactly lat cycles from now, with its mode's trigger only
  task automatic expect_launch(input int unsigned lat);
    job_t j;
    j = mq.pop_front();
    cur = j;
    for (int unsigned k = 1; k < lat; k++) cyc();
    cyc(1'b1);
    check("trig_with_galvo",    64'(oSEQ_TRIG_WITH_GALVO),    64'(j.with_galvo));
    check("trig_without_galvo", 64'(oSEQ_TRIG_WITHOUT_GALVO), 64'(!j.with_galvo));
    check_settings(j);
    check("qcount_at_launch", 64'(oQUEUE_COUNT), 64'(mq.size()));
    check("active_at_launch", 64'(oACTIVE), 64'd1);
  endtask

  // Bench sequencer: either never starts, or is busy for len cycles starting the cycle after trigger
  task automatic respond(input bit no_start, input int unsigned len, input bit abort_mid);
    if (no_start) begin
      for (int unsigned k = 1; k < START_TIMEOUT; k++) begin
        cyc();
        check("active_waiting", 64'(oACTIVE), 64'd1);
      end
      m_to = 1'b1;
      cyc();
      check("active_after_timeout", 64'(oACTIVE), 64'd0);
      check_settings(cur);
    end else begin
      iSEQ_BUSY = 1'b1;
      for (int unsigned k = 1; k <= len; k++) begin
        cyc();
        check_settings(cur);
        check("active_running", 64'(oACTIVE), 64'd1);
        check("qcount_running", 64'(oQUEUE_COUNT), 64'(mq.size()));
        if (abort_mid && k == 1) begin
          iABORT = 1'b1;
          mq.delete();
          #1;
          check("ready_in_abort", 64'(oJOB_READY), 64'd0);
        end else begin
          iABORT = 1'b0;
        end
      end
      iABORT    = 1'b0;
      iSEQ_BUSY = 1'b0;
      cyc();
      check("active_done", 64'(oACTIVE), 64'd1);
      m_done = m_done + 16'd1;
      cyc();
      check("active_idle", 64'(oACTIVE), 64'd0);
      check_settings(cur);
    end
  endtask

  // Release the sequencer and run the whole queue down, with random sequencer behaviour
  task automatic drain(input bit rnd);
    iSEQ_BUSY = 1'b0;
    while (mq.size() != 0) begin
      expect_launch(3);
      if (rnd) respond($urandom_range(0, 5) == 0, $urandom_range(3, 12), $urandom_range(0, 5) == 0);
      else     respond(1'b0, 5, 1'b0);
    end
    repeat (3) cyc();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j;
    iRST = 1'b1; iJOB_VALID = 1'b0; iABORT = 1'b0; iSEQ_BUSY = 1'b0;
    iJOB_WITH_GALVO = 1'b0; iJOB_NUM_SLM_IMAGES = '0; iJOB_CYCLES = '0; iJOB_NUM_GALVO = '0;
    iJOB_CAM_MS = '0; iJOB_GALVO_MS = '0;
    repeat (3) @(negedge iCLK);
    check_all_zero("reset");
    iRST = 1'b0;
    cyc();

    // Single no-galvo job into idle scheduler: trigger 3 cycles after acceptance, 40-cycle run
    push_cycle(1'b1, mk_job(1'b0, 3, 2, 0, 5, 7), 1'b0);
    expect_launch(3);
    respond(1'b0, 40, 1'b0);
    check("done_after_first", 64'(oJOBS_DONE), 64'd1);

    // Five offers while sequencer busy: fifth refused, four launch in order
    iSEQ_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) push_cycle(1'b1, mk_job(1'(i & 1), 10 + i, 100 + i, i + 1, i, 2 * i), 1'b0);
    check("qcount_full", 64'(oQUEUE_COUNT), 64'd4);
    drain(1'b0);
    check("done_after_four", 64'(oJOBS_DONE), 64'd5);

    // Sequencer never starts: timeout, next job still launches
    iSEQ_BUSY = 1'b1;
    push_cycle(1'b1, mk_job(1'b1, 4, 9, 3, 1, 1), 1'b0);
    push_cycle(1'b1, mk_job(1'b0, 6, 8, 0, 2, 2), 1'b0);
    iSEQ_BUSY = 1'b0;
    expect_launch(3);
    respond(1'b1, 0, 1'b0);
    expect_launch(3);
    respond(1'b0, 4, 1'b0);
    repeat (2) cyc();

    // Abort with one running and three queued: queue flushed, running job still counted
    iSEQ_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) push_cycle(1'b1, mk_job(1'b0, 20 + i, 7, 0, 3, 3), 1'b0);
    iSEQ_BUSY = 1'b0;
    expect_launch(3);
    respond(1'b0, 8, 1'b1);
    check("qcount_after_abort", 64'(oQUEUE_COUNT), 64'd0);
    repeat (6) cyc();

    // Zero-image job is rejected without stalling the host
    push_cycle(1'b1, mk_job(1'b0, 0, 5, 0, 1, 1), 1'b0);
    check("bad_job_flag", 64'(oERR_BAD_JOB), 64'd1);
    repeat (5) cyc();

    // Randomized episodes: fill while sequencer busy, then drain with random run behaviour
    for (int ep = 0; ep < 30; ep++) begin
      iSEQ_BUSY = 1'b1;
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
        j = rand_job();
        push_cycle($urandom_range(0, 3) != 0, j, $urandom_range(0, 19) == 0);
      end
      drain(1'b1);
    end

    // Galvo job, then reset while it runs: everything returns to reset values, FIFO emptied
    push_cycle(1'b1, mk_job(1'b1, 2, 3, 10, 4, 6), 1'b0);
    expect_launch(3);
    iSEQ_BUSY = 1'b1;
    cyc();
    push_cycle(1'b1, mk_job(1'b0, 5, 5, 0, 1, 1), 1'b0);
    push_cycle(1'b1, mk_job(1'b1, 5, 5, 5, 1, 1), 1'b0);
    #3 iRST = 1'b1;
    #1 check_all_zero("midrun_reset");
    mq.delete();
    m_done = 16'd0; m_bad = 1'b0; m_to = 1'b0;
    @(negedge iCLK);
    iRST = 1'b0;
    iSEQ_BUSY = 1'b0;
    repeat (6) begin
      cyc();
      check("qcount_after_reset", 64'(oQUEUE_COUNT), 64'd0);
      check("active_after_reset", 64'(oACTIVE), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
